// File: rtl/mem_lsu_stage.sv
// Load/store memory stage between EX and WB with a req/gnt/rvalid data-memory handshake.
// Builds byte enables and lane-shifted store data, extends load data, and traps misaligned accesses.
module mem_lsu_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ex_valid_i,
  input  logic [3:0]              ex_mem_op_i,
  input  logic [ADDR_WIDTH-1:0]   ex_addr_i,
  input  logic [DATA_WIDTH-1:0]   ex_wdata_i,
  input  logic                    fwd_i,
  input  logic [4:0]              ex_rd_i,
  input  logic                    ex_regwrite_i,
  output logic                    stall_o,
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [ADDR_WIDTH-1:0]   dmem_addr_o,
  output logic [DATA_WIDTH/8-1:0] dmem_be_o,
  output logic [DATA_WIDTH-1:0]   dmem_wdata_o,
  input  logic                    dmem_gnt_i,
  input  logic                    dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0]   dmem_rdata_i,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic                    wb_regwrite_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  output logic                    exc_misalign_o,
  output logic [ADDR_WIDTH-1:0]   exc_addr_o
);
  localparam int NB   = DATA_WIDTH / 8;
  localparam int OFFW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  typedef enum logic [3:0] {
    OP_NONE, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD,
    OP_SB, OP_SH, OP_SW, OP_SD
  } mem_op_e;

  // sz: 0 byte, 1 half, 2 word, 3 double
  typedef struct packed {
    logic [1:0]      sz;
    logic            uns;
    logic [OFFW-1:0] off;
    logic [4:0]      rd;
    logic            regwrite;
  } req_t;

  function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] s);
    case (s)
      2'd0:    return DATA_WIDTH'(8'hFF);
      2'd1:    return DATA_WIDTH'(16'hFFFF);
      2'd2:    return DATA_WIDTH'(32'hFFFF_FFFF);
      default: return '1;
    endcase
  endfunction

  state_t state_q, state_d;
  req_t   req_q;

  logic            is_ld, is_st, uns, misal, accept;
  logic [1:0]      sz;
  logic [OFFW-1:0] ex_off;
  logic [NB-1:0]   be_base, st_be;
  logic [DATA_WIDTH-1:0] st_src, st_data, ld_sh, ld_mask, ld_data;
  logic            ld_sign;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    uns   = 1'b0;
    sz    = 2'd0;
    case (ex_mem_op_i)
      OP_LB:   begin is_ld = 1'b1; sz = 2'd0; end
      OP_LH:   begin is_ld = 1'b1; sz = 2'd1; end
      OP_LW:   begin is_ld = 1'b1; sz = 2'd2; end
      OP_LBU:  begin is_ld = 1'b1; sz = 2'd0; uns = 1'b1; end
      OP_LHU:  begin is_ld = 1'b1; sz = 2'd1; uns = 1'b1; end
      OP_LWU:  begin is_ld = 1'b1; sz = 2'd2; uns = 1'b1; end
      OP_LD:   begin is_ld = 1'b1; sz = 2'd3; end
      OP_SB:   begin is_st = 1'b1; sz = 2'd0; end
      OP_SH:   begin is_st = 1'b1; sz = 2'd1; end
      OP_SW:   begin is_st = 1'b1; sz = 2'd2; end
      OP_SD:   begin is_st = 1'b1; sz = 2'd3; end
      default: ;
    endcase
  end

  // A 32-bit datapath has no 64-bit or zero-extended-word accesses; trap them like misalignment.
  always_comb begin
    misal = 1'b0;
    case (sz)
      2'd1:    misal = ex_addr_i[0];
      2'd2:    misal = |ex_addr_i[1:0];
      2'd3:    misal = |ex_addr_i[2:0];
      default: misal = 1'b0;
    endcase
    if (DATA_WIDTH == 32 && (sz == 2'd3 || (sz == 2'd2 && uns)))
      misal = 1'b1;
  end

  assign accept = (state_q == IDLE) && ex_valid_i;
  assign ex_off = ex_addr_i[OFFW-1:0];

  always_comb begin
    case (sz)
      2'd0:    be_base = NB'(1'b1);
      2'd1:    be_base = NB'(2'b11);
      2'd2:    be_base = NB'(4'hF);
      default: be_base = '1;
    endcase
    st_src  = fwd_i ? wb_data_o : ex_wdata_i;
    st_be   = be_base << ex_off;
    st_data = (st_src & size_mask(sz)) << {ex_off, 3'b000};
  end

  always_comb begin
    ld_sh   = dmem_rdata_i >> {req_q.off, 3'b000};
    ld_mask = size_mask(req_q.sz);
    case (req_q.sz)
      2'd0:    ld_sign = ld_sh[7];
      2'd1:    ld_sign = ld_sh[15];
      2'd2:    ld_sign = ld_sh[31];
      default: ld_sign = 1'b0;
    endcase
    ld_data = ld_sh & ld_mask;
    if (!req_q.uns && ld_sign)
      ld_data = ld_data | ~ld_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    stall_o    = (state_q != IDLE);
    dmem_req_o = (state_q == REQ);
    case (state_q)
      IDLE:    if (accept && (is_ld || is_st) && !misal) state_d = REQ;
      REQ:     if (dmem_gnt_i) state_d = dmem_we_o ? IDLE : WAIT;
      WAIT:    if (dmem_rvalid_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q          <= '0;
      dmem_we_o      <= 1'b0;
      dmem_addr_o    <= '0;
      dmem_be_o      <= '0;
      dmem_wdata_o   <= '0;
      wb_valid_o     <= 1'b0;
      wb_rd_o        <= '0;
      wb_regwrite_o  <= 1'b0;
      wb_data_o      <= '0;
      exc_misalign_o <= 1'b0;
      exc_addr_o     <= '0;
    end else begin
      wb_valid_o     <= 1'b0;
      exc_misalign_o <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (!(is_ld || is_st)) begin
            wb_valid_o    <= 1'b1;
            wb_data_o     <= DATA_WIDTH'(ex_addr_i);
            wb_rd_o       <= ex_rd_i;
            wb_regwrite_o <= ex_regwrite_i;
          end else if (misal) begin
            exc_misalign_o <= 1'b1;
            exc_addr_o     <= ex_addr_i;
            wb_valid_o     <= 1'b1;
            wb_rd_o        <= ex_rd_i;
            wb_regwrite_o  <= 1'b0;
          end else begin
            req_q        <= '{sz: sz, uns: uns, off: ex_off, rd: ex_rd_i, regwrite: ex_regwrite_i};
            dmem_we_o    <= is_st;
            dmem_addr_o  <= {ex_addr_i[ADDR_WIDTH-1:OFFW], OFFW'(0)};
            dmem_be_o    <= is_st ? st_be : '1;
            dmem_wdata_o <= is_st ? st_data : '0;
          end
        end
        REQ: if (dmem_gnt_i && dmem_we_o) begin
          wb_valid_o    <= 1'b1;
          wb_rd_o       <= req_q.rd;
          wb_regwrite_o <= 1'b0;
        end
        WAIT: if (dmem_rvalid_i) begin
          wb_valid_o    <= 1'b1;
          wb_data_o     <= ld_data;
          wb_rd_o       <= req_q.rd;
          wb_regwrite_o <= req_q.regwrite;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: one 32-bit and one 64-bit instance on a shared clock/reset.
module tb_mem_lsu_stage;
  localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4,
                         LWU = 4'd6, LD = 4'd7, SB = 4'd8, SH = 4'd9, SW = 4'd10, SD = 4'd11;

  logic clk, rst_n;

  logic        ex_valid32, fwd32, ex_regwrite32, gnt32, rvalid32;
  logic [3:0]  ex_op32;
  logic [31:0] ex_addr32, ex_wdata32, rdata32;
  logic [4:0]  ex_rd32;
  logic        stall32, req32, we32, wb_valid32, wb_regwrite32, exc32;
  logic [31:0] dmem_addr32, dmem_wdata32, wb_data32, exc_addr32;
  logic [3:0]  be32;
  logic [4:0]  wb_rd32;

  logic        ex_valid64, fwd64, ex_regwrite64, gnt64, rvalid64;
  logic [3:0]  ex_op64;
  logic [31:0] ex_addr64;
  logic [63:0] ex_wdata64, rdata64;
  logic [4:0]  ex_rd64;
  logic        stall64, req64, we64, wb_valid64, wb_regwrite64, exc64;
  logic [31:0] dmem_addr64, exc_addr64;
  logic [63:0] dmem_wdata64, wb_data64;
  logic [7:0]  be64;
  logic [4:0]  wb_rd64;

  int checks = 0;
  int errors = 0;

  mem_lsu_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid32), .ex_mem_op_i(ex_op32),
    .ex_addr_i(ex_addr32), .ex_wdata_i(ex_wdata32), .fwd_i(fwd32), .ex_rd_i(ex_rd32),
    .ex_regwrite_i(ex_regwrite32), .stall_o(stall32), .dmem_req_o(req32), .dmem_we_o(we32),
    .dmem_addr_o(dmem_addr32), .dmem_be_o(be32), .dmem_wdata_o(dmem_wdata32),
    .dmem_gnt_i(gnt32), .dmem_rvalid_i(rvalid32), .dmem_rdata_i(rdata32),
    .wb_valid_o(wb_valid32), .wb_rd_o(wb_rd32), .wb_regwrite_o(wb_regwrite32),
    .wb_data_o(wb_data32), .exc_misalign_o(exc32), .exc_addr_o(exc_addr32)
  );

  mem_lsu_stage #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .ex_valid_i(ex_valid64), .ex_mem_op_i(ex_op64),
    .ex_addr_i(ex_addr64), .ex_wdata_i(ex_wdata64), .fwd_i(fwd64), .ex_rd_i(ex_rd64),
    .ex_regwrite_i(ex_regwrite64), .stall_o(stall64), .dmem_req_o(req64), .dmem_we_o(we64),
    .dmem_addr_o(dmem_addr64), .dmem_be_o(be64), .dmem_wdata_o(dmem_wdata64),
    .dmem_gnt_i(gnt64), .dmem_rvalid_i(rvalid64), .dmem_rdata_i(rdata64),
    .wb_valid_o(wb_valid64), .wb_rd_o(wb_rd64), .wb_regwrite_o(wb_regwrite64),
    .wb_data_o(wb_data64), .exc_misalign_o(exc64), .exc_addr_o(exc_addr64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled and inputs driven 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue32(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [4:0] rd, input logic rw, input logic f);
    ex_valid32 = 1'b1; ex_op32 = op; ex_addr32 = addr; ex_wdata32 = wd;
    ex_rd32 = rd; ex_regwrite32 = rw; fwd32 = f;
  endtask

  task automatic issue64(input logic [3:0] op, input logic [31:0] addr, input logic [63:0] wd,
                         input logic [4:0] rd, input logic rw);
    ex_valid64 = 1'b1; ex_op64 = op; ex_addr64 = addr; ex_wdata64 = wd;
    ex_rd64 = rd; ex_regwrite64 = rw; fwd64 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_valid32 = 0; ex_op32 = 0; ex_addr32 = 0; ex_wdata32 = 0; fwd32 = 0;
    ex_rd32 = 0; ex_regwrite32 = 0; gnt32 = 0; rvalid32 = 0; rdata32 = 0;
    ex_valid64 = 0; ex_op64 = 0; ex_addr64 = 0; ex_wdata64 = 0; fwd64 = 0;
    ex_rd64 = 0; ex_regwrite64 = 0; gnt64 = 0; rvalid64 = 0; rdata64 = 0;
    step(); step();

    chk("rst_stall", stall32, 0);
    chk("rst_req", req32, 0);
    chk("rst_wbv", wb_valid32, 0);
    chk("rst_be", be32, 0);
    chk("rst_addr", dmem_addr32, 0);
    chk("rst_exc", exc32, 0);
    chk("rst_wbdata", wb_data32, 0);
    rst_n = 1'b1;
    step();

    // SB to the top byte lane, two cycles of grant delay
    issue32(SB, 32'h1003, 32'h0000_00A5, 5'd0, 1'b0, 1'b0);
    step();
    ex_valid32 = 0;
    chk("sb_req", req32, 1);
    chk("sb_we", we32, 1);
    chk("sb_be", be32, 4'b1000);
    chk("sb_wdata", dmem_wdata32, 32'hA500_0000);
    chk("sb_addr", dmem_addr32, 32'h1000);
    step();
    chk("sb_hold_req", req32, 1);
    chk("sb_hold_be", be32, 4'b1000);
    chk("sb_stall", stall32, 1);
    gnt32 = 1;
    step();
    gnt32 = 0;
    chk("sb_wbv", wb_valid32, 1);
    chk("sb_wbrw", wb_regwrite32, 0);
    chk("sb_idle_req", req32, 0);
    chk("sb_idle_stall", stall32, 0);
    // stray rvalid and gnt while idle are ignored
    rvalid32 = 1; gnt32 = 1;
    step();
    rvalid32 = 0; gnt32 = 0;
    chk("sb_wbv_pulse", wb_valid32, 0);
    chk("stray_req", req32, 0);
    chk("stray_stall", stall32, 0);

    // LB with a 3-cycle grant delay
    issue32(LB, 32'h2001, 32'h0, 5'd5, 1'b1, 1'b0);
    step();
    ex_valid32 = 0;
    for (int i = 0; i < 3; i++) begin
      chk("lb_stall", stall32, 1);
      chk("lb_req", req32, 1);
      chk("lb_be", be32, 4'hF);
      chk("lb_addr", dmem_addr32, 32'h2000);
      step();
    end
    gnt32 = 1;
    step();
    gnt32 = 0;
    chk("lb_wait_req", req32, 0);
    chk("lb_wait_stall", stall32, 1);
    rvalid32 = 1; rdata32 = 32'h0000_8000;
    step();
    rvalid32 = 0;
    chk("lb_wbv", wb_valid32, 1);
    chk("lb_data", wb_data32, 32'hFFFF_FF80);
    chk("lb_rd", wb_rd32, 5'd5);
    chk("lb_rw", wb_regwrite32, 1);
    chk("lb_stall_end", stall32, 0);

    // LBU with minimum latency (gnt at N+1, rvalid at N+2)
    issue32(LBU, 32'h2001, 32'h0, 5'd6, 1'b1, 1'b0);
    gnt32 = 1;
    step();
    ex_valid32 = 0;
    step();
    gnt32 = 0;
    rvalid32 = 1;
    step();
    rvalid32 = 0;
    chk("lbu_wbv", wb_valid32, 1);
    chk("lbu_data", wb_data32, 32'h0000_0080);

    // misaligned LW: exception pulse, no request
    issue32(LW, 32'h0006, 32'h0, 5'd7, 1'b1, 1'b0);
    step();
    ex_valid32 = 0;
    chk("mis_exc", exc32, 1);
    chk("mis_addr", exc_addr32, 32'h0006);
    chk("mis_wbv", wb_valid32, 1);
    chk("mis_rw", wb_regwrite32, 0);
    chk("mis_req", req32, 0);
    chk("mis_stall", stall32, 0);
    step();
    chk("mis_exc_pulse", exc32, 0);
    chk("mis_wbv_pulse", wb_valid32, 0);
    chk("mis_data_hold", wb_data32, 32'h0000_0080);

    // LD has no meaning on a 32-bit datapath
    issue32(LD, 32'h0008, 32'h0, 5'd8, 1'b1, 1'b0);
    step();
    ex_valid32 = 0;
    chk("ld32_exc", exc32, 1);
    chk("ld32_addr", exc_addr32, 32'h0008);
    chk("ld32_req", req32, 0);

    // SH on upper half, LH sign extension from upper half
    issue32(SH, 32'h1002, 32'h1234_ABCD, 5'd0, 1'b0, 1'b0);
    step();
    ex_valid32 = 0;
    chk("sh_be", be32, 4'b1100);
    chk("sh_wdata", dmem_wdata32, 32'hABCD_0000);
    gnt32 = 1;
    step();
    gnt32 = 0;
    issue32(LH, 32'h1002, 32'h0, 5'd9, 1'b1, 1'b0);
    step();
    ex_valid32 = 0;
    gnt32 = 1;
    step();
    gnt32 = 0;
    rvalid32 = 1; rdata32 = 32'h8001_0000;
    step();
    rvalid32 = 0;
    chk("lh_data", wb_data32, 32'hFFFF_8001);

    // NONE then SW forwarding its result; next NONE is held until the store completes
    issue32(NONE, 32'hDEAD_BEEF, 32'h0, 5'd3, 1'b1, 1'b0);
    step();
    chk("none_wbv", wb_valid32, 1);
    chk("none_data", wb_data32, 32'hDEAD_BEEF);
    chk("none_rd", wb_rd32, 5'd3);
    chk("none_rw", wb_regwrite32, 1);
    issue32(SW, 32'h0040, 32'h1111_1111, 5'd0, 1'b0, 1'b1);
    step();
    chk("fwd_wdata", dmem_wdata32, 32'hDEAD_BEEF);
    chk("fwd_be", be32, 4'hF);
    issue32(NONE, 32'h0000_0055, 32'h0, 5'd4, 1'b1, 1'b0);
    step();
    chk("b2b_held", wb_valid32, 0);
    gnt32 = 1;
    step();
    gnt32 = 0;
    chk("b2b_st_wbv", wb_valid32, 1);
    chk("b2b_st_rw", wb_regwrite32, 0);
    step();
    ex_valid32 = 0;
    chk("b2b_none_wbv", wb_valid32, 1);
    chk("b2b_none_data", wb_data32, 32'h0000_0055);
    chk("b2b_none_rd", wb_rd32, 5'd4);

    // 64-bit datapath: SD, LWU, LW from the upper word
    issue64(SD, 32'h0010, 64'h0123_4567_89AB_CDEF, 5'd0, 1'b0);
    step();
    ex_valid64 = 0;
    chk("sd_be", be64, 8'hFF);
    chk("sd_wdata", dmem_wdata64, 64'h0123_4567_89AB_CDEF);
    chk("sd_addr", dmem_addr64, 32'h0010);
    gnt64 = 1;
    step();
    gnt64 = 0;
    chk("sd_wbv", wb_valid64, 1);
    issue64(LWU, 32'h0014, 64'h0, 5'd10, 1'b1);
    step();
    ex_valid64 = 0;
    chk("lwu_addr", dmem_addr64, 32'h0010);
    gnt64 = 1;
    step();
    gnt64 = 0;
    rvalid64 = 1; rdata64 = 64'h8765_4321_0000_0000;
    step();
    rvalid64 = 0;
    chk("lwu_data", wb_data64, 64'h0000_0000_8765_4321);
    issue64(LW, 32'h0014, 64'h0, 5'd11, 1'b1);
    step();
    ex_valid64 = 0;
    gnt64 = 1;
    step();
    gnt64 = 0;
    rvalid64 = 1;
    step();
    rvalid64 = 0;
    chk("lw64_data", wb_data64, 64'hFFFF_FFFF_8765_4321);

    // reset while waiting for read data
    issue32(LW, 32'h0100, 32'h0, 5'd12, 1'b1, 1'b0);
    gnt32 = 1;
    step();
    ex_valid32 = 0;
    step();
    gnt32 = 0;
    chk("rw_wait_stall", stall32, 1);
    rst_n = 1'b0;
    #1;
    chk("rw_req", req32, 0);
    chk("rw_stall", stall32, 0);
    chk("rw_wbv", wb_valid32, 0);
    step();
    rst_n = 1'b1;
    rvalid32 = 1; rdata32 = 32'h1234_5678;
    step();
    rvalid32 = 0;
    chk("rw_late_wbv", wb_valid32, 0);
    chk("rw_late_stall", stall32, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
